// File: rtl/line_window_gen_if.sv
`default_nettype none
// ============================================================================
// line_window_gen_if : pixel-in / column-triple-out streaming bus
// Rev 1.0
// ============================================================================
interface line_window_gen_if #(
    parameter int DATA_W = 24
);
    logic              in_valid;
    logic              in_sof;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_row0;
    logic [DATA_W-1:0] out_row1;
    logic [DATA_W-1:0] out_row2;
    logic              out_sof;
    logic              out_eol;

    // master = pixel source / window consumer, slave = the generator
    modport master (
        output in_valid, in_sof, in_data,
        input  out_valid, out_row0, out_row1, out_row2, out_sof, out_eol
    );
    modport slave (
        input  in_valid, in_sof, in_data,
        output out_valid, out_row0, out_row1, out_row2, out_sof, out_eol
    );
endinterface
`default_nettype wire

// File: rtl/line_window_gen.sv
`default_nettype none
// ============================================================================
// line_window_gen : 3-row column generator over two read-first line buffers.
// Optional top-border replication: BORDER_REPLICATE_EN.   Rev 1.0
// ============================================================================
module line_window_gen #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 11,
    parameter int LINE_W = 1920
) (
    input  wire logic         clk,
    input  wire logic         rst,
    line_window_gen_if.slave  pix_io
);
    localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(LINE_W - 1);
    localparam int                DEPTH  = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ROW_FIRST  = 2'd0,
        ROW_SECOND = 2'd1,
        ROW_STEADY = 2'd2
    } row_e;

    logic [DATA_W-1:0] mem_a_q [DEPTH];
    logic [DATA_W-1:0] mem_b_q [DEPTH];

    logic [ADDR_W-1:0] x_q, x_d;
    row_e              rc_q, rc_d;
    logic [ADDR_W-1:0] cur_x;
    row_e              cur_rc;
    logic              emit;
    logic              bwr_q;
    logic [ADDR_W-1:0] bx_q;
    logic [DATA_W-1:0] rd_a_q, rd_b_q, row0_q;
    logic              valid_q, sof_q, eol_q;

    // in_sof forces the accepted pixel to (0,0) regardless of counter state
    always_comb begin
        cur_x  = pix_io.in_sof ? '0 : x_q;
        cur_rc = pix_io.in_sof ? ROW_FIRST : rc_q;
        x_d    = x_q;
        rc_d   = rc_q;
        if (pix_io.in_valid) begin
            if (cur_x == X_LAST) begin
                x_d  = '0;
                rc_d = (cur_rc == ROW_FIRST) ? ROW_SECOND : ROW_STEADY;
            end else begin
                x_d  = cur_x + 1'b1;
                rc_d = cur_rc;
            end
        end
    end

`ifdef BORDER_REPLICATE_EN
    assign emit = pix_io.in_valid;
`else
    assign emit = pix_io.in_valid && (cur_rc == ROW_STEADY);
`endif

    // B is fed from A's read port one cycle late; a reset drops that write
    always_ff @(posedge clk) begin
        if (pix_io.in_valid && !rst) begin
            mem_a_q[cur_x] <= pix_io.in_data;
        end
        if (bwr_q && !rst) begin
            mem_b_q[bx_q] <= rd_a_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            rc_q    <= ROW_FIRST;
            bwr_q   <= 1'b0;
            bx_q    <= '0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            row0_q  <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
        end else begin
            x_q     <= x_d;
            rc_q    <= rc_d;
            bwr_q   <= pix_io.in_valid;
            valid_q <= emit;
            sof_q   <= emit && (cur_x == '0) && (cur_rc == ROW_FIRST);
            eol_q   <= emit && (cur_x == X_LAST);
            if (pix_io.in_valid) begin
                bx_q   <= cur_x;
                row0_q <= pix_io.in_data;
                rd_a_q <= mem_a_q[cur_x];
                rd_b_q <= mem_b_q[cur_x];
            end
        end
    end

    assign pix_io.out_valid = valid_q;
    assign pix_io.out_sof   = sof_q;
    assign pix_io.out_eol   = eol_q;
    assign pix_io.out_row0  = row0_q;

`ifdef BORDER_REPLICATE_EN
    row_e orc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            orc_q <= ROW_FIRST;
        end else if (pix_io.in_valid) begin
            orc_q <= cur_rc;
        end
    end

    // Rows above the frame top are replaced by the nearest real row
    assign pix_io.out_row1 = (orc_q == ROW_FIRST)  ? row0_q : rd_a_q;
    assign pix_io.out_row2 = (orc_q == ROW_STEADY) ? rd_b_q : pix_io.out_row1;
`else
    assign pix_io.out_row1 = rd_a_q;
    assign pix_io.out_row2 = rd_b_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_line_window_gen.sv
`default_nettype none
// ============================================================================
// tb_line_window_gen : directed + randomized checks against a frame model
// Rev 1.0
// ============================================================================
module tb_line_window_gen;
    localparam int DW = 24;
    localparam int AW = 2;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_window_gen_if #(.DATA_W(DW)) bus ();

    line_window_gen #(.DATA_W(DW), .ADDR_W(AW), .LINE_W(LW)) dut (
        .clk    (clk),
        .rst    (rst),
        .pix_io (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference: frame stored as a flat pixel map indexed by y*LW+x
    logic [DW-1:0] fm [int];
    int            mx, my;
    logic          ev, esof, eeol, erst;
    logic [DW-1:0] er0, er1, er2;
    int            vcount;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_pixel(input logic s, input logic [DW-1:0] d);
        if (s) begin
            mx = 0;
            my = 0;
            fm.delete();
        end
        fm[my*LW + mx] = d;
`ifdef BORDER_REPLICATE_EN
        ev = 1'b1;
`else
        ev = (my >= 2);
`endif
        er0  = d;
        er1  = (my >= 1) ? fm[(my-1)*LW + mx] : d;
        er2  = (my >= 2) ? fm[(my-2)*LW + mx] : er1;
        esof = ev && (mx == 0) && (my == 0);
        eeol = ev && (mx == LW-1);
        mx++;
        if (mx == LW) begin
            mx = 0;
            my++;
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [DW-1:0] d, input logic r);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_sof   = s;
        bus.in_data  = d;
        rst          = r;
        erst = 1'b0;
        if (r) begin
            mx = 0; my = 0; fm.delete();
            ev = 1'b0; esof = 1'b0; eeol = 1'b0; erst = 1'b1;
            er0 = '0; er1 = '0; er2 = '0;
        end else if (v) begin
            model_pixel(s, d);
        end else begin
            ev = 1'b0; esof = 1'b0; eeol = 1'b0;
        end
        @(posedge clk);
        #1;
        if (bus.out_valid) vcount++;
        chk("valid", bus.out_valid, ev);
        chk("sof",   bus.out_sof,   esof);
        chk("eol",   bus.out_eol,   eeol);
        if (ev || erst) begin
            chk("row0", bus.out_row0, er0);
            chk("row1", bus.out_row1, er1);
            chk("row2", bus.out_row2, er2);
        end
    endtask

    task automatic pix(input int gap_max, input logic s, input logic [DW-1:0] d);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        repeat (g) step(1'b0, 1'b0, '0, 1'b0);
        step(1'b1, s, d, 1'b0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = '0;
        mx = 0; my = 0;
        ev = 0; esof = 0; eeol = 0; erst = 0;
        er0 = '0; er1 = '0; er2 = '0;
        vcount = 0;

        // Reset state
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Continuous 4x4 frame, value 16*y+x
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < LW; x++)
                pix(0, (x == 0 && y == 0), DW'(16*y + x));
        pix(0, 1'b0, DW'(8'h20));
        chk("first_valid", bus.out_valid, 1'b1);
        chk("first_r0", bus.out_row0, DW'(8'h20));
        chk("first_r1", bus.out_row1, DW'(8'h10));
        chk("first_r2", bus.out_row2, DW'(8'h00));
        for (int x = 1; x < LW; x++) pix(0, 1'b0, DW'(16*2 + x));
        for (int x = 0; x < LW; x++) pix(0, 1'b0, DW'(16*3 + x));
        chk("p33_r0", bus.out_row0, DW'(8'h33));
        chk("p33_r1", bus.out_row1, DW'(8'h23));
        chk("p33_r2", bus.out_row2, DW'(8'h13));
        chk("p33_eol", bus.out_eol, 1'b1);

        // Same stream with random 0-3 cycle gaps
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < LW; x++)
                pix(3, (x == 0 && y == 0), DW'(16*y + x));

        // New frame started at what would be (2,3)
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < LW; x++)
                if (y < 3 || x < 2) pix(1, (x == 0 && y == 0), DW'(16*y + x));
        vcount = 0;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < LW; x++) begin
                pix(1, (x == 0 && y == 0), DW'(24'h100 + 16*y + x));
`ifndef BORDER_REPLICATE_EN
                if (y == 1 && x == LW-1) chk("sof_quiet8", DW'(vcount), '0);
`endif
            end

        // Reset pulsed at (2,2), next pixel becomes (0,0) without in_sof
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < LW; x++)
                if (y < 2 || x < 2) pix(0, (x == 0 && y == 0), DW'(16*y + x));
        step(1'b1, 1'b0, DW'(8'h22), 1'b1);
        vcount = 0;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < LW; x++) begin
                pix(2, 1'b0, DW'(24'h200 + 16*y + x));
`ifndef BORDER_REPLICATE_EN
                if (y == 1 && x == LW-1) chk("rst_quiet8", DW'(vcount), '0);
`endif
            end

        // Randomized data, gaps and occasional restarts
        for (int f = 0; f < 3; f++)
            for (int y = 0; y < 6; y++)
                for (int x = 0; x < LW; x++)
                    pix(3, (x == 0 && y == 0) || ($urandom_range(0, 60) == 0),
                        DW'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
